// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg
//   Shared CPU-side types for the fetch/decode boundary: the queued fetch
//   entry and the CP0 ExcCode values fetch can raise.
package instr_fetch_queue_pkg;

  // CP0 ExcCode values raised at fetch time
  localparam logic [4:0] EXC_ADEL = 5'h04;  // address error on instruction load
  localparam logic [4:0] EXC_TLBL = 5'h02;  // ITLB refill / invalid

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [4:0]  exc_code;
  } fetch_entry_t;

  // Build the stored form of a fetched word. A faulting fetch carries no
  // usable instruction, so its word becomes a nop (32'h0) and decode
  // produces no register write; exc_code is zeroed for clean entries.
  function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                              input logic [31:0] instr,
                                              input logic        exc,
                                              input logic [4:0]  exc_code);
    fetch_entry_t e;
    e.pc       = pc;
    e.instr    = exc ? 32'h0 : instr;
    e.exc      = exc;
    e.exc_code = exc ? exc_code : 5'h0;
    return e;
  endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Decoupling FIFO between instruction fetch and decode. Holds up to DEPTH
//   fetched words with PC and fetch exception; the oldest entry is presented
//   to decode. A redirect (flush) discards everything in one edge.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    redirect: empty the queue this edge
//   in_valid/in_ready        fetch handshake; in_pc, in_instr, in_exc, in_exc_code
//   out_valid/out_ready      decode handshake; out_pc, out_instr, out_exc, out_exc_code
//   count                    occupancy 0..DEPTH
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic             in_exc,
  input  logic [4:0]       in_exc_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_exc,
  output logic [4:0]       out_exc_code,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  fetch_entry_t       mem [DEPTH];
  fetch_entry_t       head;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               push, pop;

  // in_ready looks only at occupancy: a full queue refuses a push even if
  // decode pops in the same cycle, keeping in_ready off the out_ready path.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Pointers and occupancy. DEPTH is a power of two, so the +1 wraps
  // DEPTH-1 -> 0 on its own with no bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers qualify its contents. push is
  // already gated by flush; rst is added so nothing lands during reset.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= make_entry(in_pc, in_instr, in_exc, in_exc_code);
  end

  // Head is read straight out of storage: an entry written at edge N shows
  // after edge N, with no same-cycle bypass from the input.
  assign head         = mem[rd_ptr];
  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_exc      = head.exc;
  assign out_exc_code = head.exc_code;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_exc;
  logic [31:0]      in_pc, in_instr;
  logic [4:0]       in_exc_code;
  logic             out_valid, out_ready, out_exc;
  logic [31:0]      out_pc, out_instr;
  logic [4:0]       out_exc_code;
  logic [PTR_W:0]   count;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_exc_code(in_exc_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .out_exc_code(out_exc_code),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [4:0]  code;
  } exp_t;

  // Reference model: the queue contents as a plain list, oldest first.
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model update at each edge from the rules: reset/flush empty the list;
  // otherwise accept when not full (judged before any pop), pop when
  // non-empty and decode is ready. Faulting words are expected as nop.
  always @(posedge clk) begin
    if (rst || flush)
      exp_q.delete();
    else if (in_valid && exp_q.size() < DEPTH) begin
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back('{in_pc, (in_exc ? 32'h0 : in_instr), in_exc, (in_exc ? in_exc_code : 5'h0)});
    end else if (out_ready && exp_q.size() != 0)
      void'(exp_q.pop_front());
  end

  // Monitor: away from the active edge, compare status and the head entry.
  always @(negedge clk) begin
    if (checking) begin
      chk("count",     32'(count),     32'(exp_q.size()));
      chk("in_ready",  32'(in_ready),  32'(exp_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_pc",    out_pc,         exp_q[0].pc);
        chk("out_instr", out_instr,      exp_q[0].instr);
        chk("out_exc",   32'(out_exc),   32'(exp_q[0].exc));
        if (exp_q[0].exc) chk("out_exc_code", 32'(out_exc_code), 32'(exp_q[0].code));
      end
    end
  end

  // One cycle of stimulus; inputs change just after the monitor's sample.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ex, input logic [4:0] code, input logic ordy,
                     input logic fl, input logic r);
    in_valid = v; in_pc = pc; in_instr = ins; in_exc = ex; in_exc_code = code;
    out_ready = ordy; flush = fl; rst = r;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 5'h0, ordy, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic ordy);
    cyc(1'b1, pc, pc ^ 32'h5A5A_0000, 1'b0, 5'h0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    in_exc = 1'b0; in_exc_code = '0; out_ready = 1'b0;
    @(negedge clk); #1;
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    checking = 1'b1;

    // reset idle, then first push visible next cycle
    idle(1'b0, 2);
    cyc(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 5'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // fill to full, refused 9th, pop one, head becomes entry 2
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 4*i, 1'b0);
    push(32'h2000, 1'b0);
    push(32'h2004, 1'b1);  // full + pop same cycle: still refused
    idle(1'b0, 1);
    push(32'h2008, 1'b0);  // room again
    idle(1'b1, DEPTH + 1);

    // stream 20 entries, 1/cycle, pointers wrap
    for (int i = 0; i < 20; i++) push(32'h3000 + 4*i, 1'b1);
    idle(1'b1, 2);

    // hold 3, flush with an entry presented; it must never appear
    for (int i = 0; i < 3; i++) push(32'h4000 + 4*i, 1'b0);
    cyc(1'b1, 32'h8000_0180, 32'h1234_5678, 1'b0, 5'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1);
    push(32'h8000_0184, 1'b0);
    idle(1'b1, 2);

    // fetch exception: word forced to nop
    cyc(1'b1, 32'h0040_0002, 32'hFFFF_FFFF, 1'b1, EXC_ADEL, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0040_1000, 32'hFFFF_FFFF, 1'b1, EXC_TLBL, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 3);

    // reset mid-stream at count=5 with flush and push/pop active
    for (int i = 0; i < 5; i++) push(32'h5000 + 4*i, 1'b0);
    cyc(1'b1, 32'h6000, 32'h6000, 1'b0, 5'h0, 1'b1, 1'b1, 1'b1);
    idle(1'b0, 2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic ex;
      ex = ($urandom_range(7) == 0);
      cyc(($urandom_range(3) != 0), $urandom, $urandom, ex,
          (($urandom_range(1) != 0) ? EXC_ADEL : EXC_TLBL),
          ($urandom_range(2) != 0), ($urandom_range(40) == 0), ($urandom_range(150) == 0));
    end
    idle(1'b1, DEPTH + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Decoupling FIFO between instruction fetch (I-cache/ITLB response) and the decode stage. Buffers fetched words with their PC and any fetch-time exception, presents the oldest entry to decode as `MipsInstr`, and discards all contents on a pipeline redirect (branch/jump resolution, exception, `eret`). Absorbs I-cache latency and decode stalls so fetch can run ahead by up to `DEPTH` instructions.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..32.
- `PTR_W`, $clog2(DEPTH): pointer width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  redirect; empties the queue this edge.
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  queue accepts the entry this cycle.
- `in_pc`  in  32  PC of the fetched word.
- `in_instr`  in  32  fetched word.
- `in_exc`  in  1  fetch exception (AdEL / ITLB refill / ITLB invalid).
- `in_exc_code`  in  5  CP0 ExcCode of the fetch exception; ignored when `in_exc`=0.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  decode consumes the head this cycle.
- `out_pc`  out  32  head PC.
- `out_instr`  out  32  head word; drives decoder `MipsInstr`. Forced to 32'h0 (nop) when `in_exc` was set for the entry.
- `out_exc`  out  1  head fetch exception.
- `out_exc_code`  out  5  head ExcCode.
- `count`  out  PTR_W+1  occupancy, 0..DEPTH.

## Operation
- Circular buffer with `rd_ptr`, `wr_ptr` (PTR_W bits, wrap modulo DEPTH) and `count`.
- Push = `in_valid & in_ready & ~flush`; pop = `out_valid & out_ready & ~flush`.
- `in_ready` = (`count` != DEPTH). It does not depend on `out_ready`: no push into a full queue even when a pop occurs the same cycle.
- `out_valid` = (`count` != 0); head fields read combinationally from `mem[rd_ptr]`.
- Push and pop in the same cycle: both pointers advance, `count` unchanged. Legal at any non-full, non-empty occupancy.
- Exception entries are stored as-is, with the instruction word replaced by 0 at write time, so decode sees a nop and no register write; `out_exc` carries the fault to the exception logic.
- `flush` has priority over push and pop: `rd_ptr`, `wr_ptr`, `count` all go to 0. An entry presented with `in_valid` in the flush cycle is dropped, and `in_ready` is not consulted. Fetch must re-present from the redirected PC.
- Storage (`mem`) is not reset; only pointers/count are. Output data fields are don't-care whenever `out_valid`=0 and must not be checked.

## Timing
- Reset (`rst`=1 at edge): `count`=0, pointers=0 → `out_valid`=0, `in_ready`=1 from the next cycle. `rst` overrides `flush`, push, and pop.
- Enqueue-to-dequeue latency: 1 cycle. An entry pushed at edge N is visible on `out_*` after edge N, with no same-cycle bypass.
- Full boundary: at `count`=DEPTH, `in_ready`=0. `in_ready` returns to 1 the cycle after the first pop.
- Empty boundary: a pop of the last entry with no simultaneous push gives `out_valid`=0 the next cycle.
- Pointer wrap: `wr_ptr`/`rd_ptr` roll from DEPTH-1 to 0 with no bubble.
- Flush: queue empty after the flush edge. `out_valid`=0 and `in_ready`=1 in the following cycle.
- Throughput: 1 entry/cycle sustained when fetch and decode are both unblocked.

## Structure
- The entry typedef `fetch_entry_t` {pc[31:0], instr[31:0], exc, exc_code[4:0]} goes in the shared CPU package, alongside the ExcCode constants (`EXC_ADEL`=5'h04, `EXC_TLBL`=5'h02).
- Single module with no sub-module. Pointer/count logic is small enough to stay inline.

## Test plan
- Reset then idle → `out_valid`=0, `in_ready`=1, `count`=0; push pc=32'hBFC0_0000 / instr=32'h2408_0001 → next cycle `out_pc`=BFC0_0000, `out_instr`=2408_0001, `count`=1.
- Push 8 entries with `out_ready`=0 (DEPTH=8) → `count`=8, `in_ready`=0. A 9th `in_valid` is not accepted. Pop one → `in_ready`=1 next cycle, and the head is entry 2.
- Streaming 20 entries with `in_valid`=`out_ready`=1 → outputs appear in order 1 cycle after input, pointers wrap twice, and `count` stays 1.
- Hold 3 entries, assert `flush` together with `in_valid` (pc=32'h8000_0180) → next cycle `count`=0, `out_valid`=0. The flushed-cycle entry is never output.
- Push an entry with `in_exc`=1, `in_exc_code`=5'h04, `in_instr`=32'hFFFF_FFFF → out shows `out_exc`=1, `out_exc_code`=04, `out_instr`=32'h0.
- Assert `rst` mid-stream with `count`=5 and `flush`=1 → after the edge `count`=0, `in_ready`=1, `out_valid`=0.
